// File: rtl/cap_err_chk.sv
// Checker for injected CHERI load/store capability faults: arms on injection, waits for the matching trap.
// Pass/fail pulses are registered one cycle after the deciding event; pure observer, never stalls the core.
module cap_err_chk #(
  parameter int TIMEOUT_CYC = 64,
  parameter int CNT_W       = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inj_valid,
  input  logic [2:0]       inj_type,
  input  logic [1:0]       inj_perm_sel,
  input  logic             inj_we,
  input  logic             inj_giveup,
  input  logic [31:0]      inj_pc,
  input  logic             instr_retire,
  input  logic [31:0]      retire_pc,
  input  logic             exc_valid,
  input  logic [5:0]       exc_mcause,
  input  logic [4:0]       exc_cheri_cause,
  input  logic [31:0]      exc_pc,
  output logic             chk_pass,
  output logic             chk_fail,
  output logic [2:0]       fail_code,
  output logic             fail_sticky,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt
);

  localparam int            TW          = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
  localparam logic [TW-1:0] TMAX        = TW'(TIMEOUT_CYC - 1);
  localparam logic [2:0]    FC_MISMATCH = 3'd1;
  localparam logic [2:0]    FC_NO_EXC   = 3'd2;
  localparam logic [2:0]    FC_TIMEOUT  = 3'd3;
  localparam logic [2:0]    FC_OVERRUN  = 3'd4;

  typedef enum logic {
    S_IDLE,
    S_WAIT
  } state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic [31:0]       r_pc;
  logic              r_align;
  logic [5:0]        r_exp_mcause;
  logic [4:0]        r_exp_cause;
  logic [TW-1:0]     r_timer;
  logic [TW-1:0]     w_timer_nxt;
  logic              r_pass;
  logic              r_fail;
  logic [2:0]        r_fail_code;
  logic              r_sticky;
  logic [CNT_W-1:0]  r_pass_cnt;
  logic [CNT_W-1:0]  r_fail_cnt;

  logic              w_arm_req;
  logic              w_load;
  logic              w_pass_nxt;
  logic              w_fail_nxt;
  logic [2:0]        w_code_nxt;
  logic              w_arm_align;
  logic [5:0]        w_arm_mcause;
  logic [4:0]        w_arm_cause;
  logic              w_exc_hit;
  logic              w_ret_hit;
  logic              w_cause_ok;

  assign w_arm_req = inj_valid & ~inj_giveup;
  assign w_exc_hit = exc_valid & (exc_pc == r_pc);
  assign w_ret_hit = instr_retire & (retire_pc == r_pc);
  // Misaligned accesses raise a plain RISC-V exception, so only mcause is meaningful there.
  assign w_cause_ok = (exc_mcause == r_exp_mcause) &
                      (r_align | (exc_cheri_cause == r_exp_cause));

  always_comb begin
    w_arm_align  = 1'b0;
    w_arm_mcause = 6'h1C;
    w_arm_cause  = 5'h00;
    case (inj_type)
      3'd0: w_arm_cause = 5'h02;
      3'd1: w_arm_cause = 5'h03;
      3'd2: begin
        case (inj_perm_sel)
          2'd0:    w_arm_cause = 5'h12;
          2'd1:    w_arm_cause = 5'h13;
          default: w_arm_cause = 5'h15;
        endcase
      end
      3'd3: w_arm_cause = 5'h01;
      3'd4: begin
        w_arm_align  = 1'b1;
        w_arm_mcause = inj_we ? 6'd6 : 6'd4;
      end
      default: w_arm_cause = 5'h00;
    endcase
  end

  always_comb begin
    w_state_nxt = r_state;
    w_timer_nxt = r_timer;
    w_load      = 1'b0;
    w_pass_nxt  = 1'b0;
    w_fail_nxt  = 1'b0;
    w_code_nxt  = 3'd0;
    case (r_state)
      S_IDLE: begin
        if (w_arm_req) begin
          w_state_nxt = S_WAIT;
          w_load      = 1'b1;
          w_timer_nxt = '0;
        end
      end
      S_WAIT: begin
        // Resolution order: matching trap, clean retire, new injection, timeout.
        if (w_exc_hit) begin
          w_state_nxt = S_IDLE;
          w_pass_nxt  = w_cause_ok;
          w_fail_nxt  = ~w_cause_ok;
          w_code_nxt  = FC_MISMATCH;
        end else if (w_ret_hit) begin
          w_state_nxt = S_IDLE;
          w_fail_nxt  = 1'b1;
          w_code_nxt  = FC_NO_EXC;
        end else if (w_arm_req && (inj_pc != r_pc)) begin
          w_fail_nxt  = 1'b1;
          w_code_nxt  = FC_OVERRUN;
          w_load      = 1'b1;
          w_timer_nxt = '0;
        end else if (r_timer == TMAX) begin
          w_state_nxt = S_IDLE;
          w_fail_nxt  = 1'b1;
          w_code_nxt  = FC_TIMEOUT;
        end else begin
          w_timer_nxt = r_timer + TW'(1);
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state      <= S_IDLE;
      r_timer      <= '0;
      r_pc         <= '0;
      r_align      <= 1'b0;
      r_exp_mcause <= '0;
      r_exp_cause  <= '0;
      r_pass       <= 1'b0;
      r_fail       <= 1'b0;
      r_fail_code  <= '0;
      r_sticky     <= 1'b0;
      r_pass_cnt   <= '0;
      r_fail_cnt   <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_timer <= w_timer_nxt;
      r_pass  <= w_pass_nxt;
      r_fail  <= w_fail_nxt;
      if (w_load) begin
        r_pc         <= inj_pc;
        r_align      <= w_arm_align;
        r_exp_mcause <= w_arm_mcause;
        r_exp_cause  <= w_arm_cause;
      end
      if (w_fail_nxt) begin
        r_fail_code <= w_code_nxt;
        r_sticky    <= 1'b1;
        if (r_fail_cnt != '1) r_fail_cnt <= r_fail_cnt + CNT_W'(1);
      end
      if (w_pass_nxt && (r_pass_cnt != '1)) r_pass_cnt <= r_pass_cnt + CNT_W'(1);
    end
  end

  assign chk_pass    = r_pass;
  assign chk_fail    = r_fail;
  assign fail_code   = r_fail_code;
  assign fail_sticky = r_sticky;
  assign pass_cnt    = r_pass_cnt;
  assign fail_cnt    = r_fail_cnt;

endmodule

// File: tb/tb_cap_err_chk.sv
// Bench for cap_err_chk: directed vector table, multi-cycle corner sequences, then random traffic vs a reference model.
module tb_cap_err_chk;
  localparam int TO = 64;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        inj_valid, inj_we, inj_giveup, instr_retire, exc_valid;
  logic [2:0]  inj_type;
  logic [1:0]  inj_perm_sel;
  logic [31:0] inj_pc, retire_pc, exc_pc;
  logic [5:0]  exc_mcause;
  logic [4:0]  exc_cheri_cause;
  logic        chk_pass, chk_fail, fail_sticky;
  logic [2:0]  fail_code;
  logic [15:0] pass_cnt, fail_cnt;
  logic        chk_pass2, chk_fail2, fail_sticky2;
  logic [2:0]  fail_code2;
  logic [1:0]  pass_cnt2, fail_cnt2;

  always #5 clk = ~clk;

  cap_err_chk #(.TIMEOUT_CYC(TO), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .inj_valid(inj_valid), .inj_type(inj_type),
    .inj_perm_sel(inj_perm_sel), .inj_we(inj_we), .inj_giveup(inj_giveup), .inj_pc(inj_pc),
    .instr_retire(instr_retire), .retire_pc(retire_pc), .exc_valid(exc_valid),
    .exc_mcause(exc_mcause), .exc_cheri_cause(exc_cheri_cause), .exc_pc(exc_pc),
    .chk_pass(chk_pass), .chk_fail(chk_fail), .fail_code(fail_code),
    .fail_sticky(fail_sticky), .pass_cnt(pass_cnt), .fail_cnt(fail_cnt));

  cap_err_chk #(.TIMEOUT_CYC(TO), .CNT_W(2)) u_dut2 (
    .clk(clk), .rst_n(rst_n), .inj_valid(inj_valid), .inj_type(inj_type),
    .inj_perm_sel(inj_perm_sel), .inj_we(inj_we), .inj_giveup(inj_giveup), .inj_pc(inj_pc),
    .instr_retire(instr_retire), .retire_pc(retire_pc), .exc_valid(exc_valid),
    .exc_mcause(exc_mcause), .exc_cheri_cause(exc_cheri_cause), .exc_pc(exc_pc),
    .chk_pass(chk_pass2), .chk_fail(chk_fail2), .fail_code(fail_code2),
    .fail_sticky(fail_sticky2), .pass_cnt(pass_cnt2), .fail_cnt(fail_cnt2));

  int n_pass = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    if (act === exp) n_pass++;
    else begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: an open expectation with its age in cycles since arming, true (unbounded) counts.
  bit          m_armed, m_align, m_pass, m_fail, m_sticky;
  int          m_age, m_code, m_pcnt, m_fcnt;
  logic [31:0] m_pc;
  logic [5:0]  m_mc;
  logic [4:0]  m_cc;

  function automatic int sat(input int v, input int maxv);
    return (v > maxv) ? maxv : v;
  endfunction

  task automatic model_arm();
    m_armed = 1; m_age = 0; m_pc = inj_pc; m_align = (inj_type == 3'd4);
    m_mc = m_align ? (inj_we ? 6'd6 : 6'd4) : 6'h1C;
    case (inj_type)
      3'd0: m_cc = 5'h02;
      3'd1: m_cc = 5'h03;
      3'd3: m_cc = 5'h01;
      3'd2: m_cc = (inj_perm_sel == 2'd0) ? 5'h12 : (inj_perm_sel == 2'd1) ? 5'h13 : 5'h15;
      default: m_cc = 5'h00;
    endcase
  endtask

  task automatic model_fail(input int code);
    m_fail = 1; m_code = code; m_sticky = 1; m_fcnt++;
  endtask

  task automatic model_step();
    bit arm_req;
    arm_req = inj_valid && !inj_giveup;
    m_pass = 0; m_fail = 0;
    if (!rst_n) begin
      m_armed = 0; m_code = 0; m_sticky = 0; m_pcnt = 0; m_fcnt = 0;
    end else if (!m_armed) begin
      if (arm_req) model_arm();
    end else begin
      m_age++;
      if (exc_valid && exc_pc == m_pc) begin
        m_armed = 0;
        if (exc_mcause == m_mc && (m_align || exc_cheri_cause == m_cc)) begin
          m_pass = 1; m_pcnt++;
        end else model_fail(1);
      end else if (instr_retire && retire_pc == m_pc) begin
        m_armed = 0; model_fail(2);
      end else if (arm_req && inj_pc != m_pc) begin
        model_fail(4); model_arm();
      end else if (m_age == TO) begin
        m_armed = 0; model_fail(3);
      end
    end
  endtask

  task automatic drive_cycle();
    model_step();
    @(posedge clk);
    #1;
    check("out", {chk_pass, chk_fail, fail_code, fail_sticky, pass_cnt, fail_cnt},
          {m_pass, m_fail, 3'(m_code), m_sticky, 16'(sat(m_pcnt, 65535)), 16'(sat(m_fcnt, 65535))});
    check("cnt2", {pass_cnt2, fail_cnt2}, {2'(sat(m_pcnt, 3)), 2'(sat(m_fcnt, 3))});
  endtask

  task automatic idle_inputs();
    inj_valid = 0; inj_type = 0; inj_perm_sel = 0; inj_we = 0; inj_giveup = 0; inj_pc = 0;
    instr_retire = 0; retire_pc = 0; exc_valid = 0; exc_mcause = 0; exc_cheri_cause = 0; exc_pc = 0;
  endtask

  typedef struct {
    bit iv; bit [2:0] ty; bit [1:0] ps; bit we; bit gu; bit [31:0] ipc;
    bit rt; bit [31:0] rpc;
    bit ev; bit [5:0] mc; bit [4:0] cc; bit [31:0] epc;
    bit ep; bit ef; bit [2:0] ec;
  } vec_t;

  function automatic vec_t v_idle();
    vec_t v;
    v.iv = 0; v.ty = 0; v.ps = 0; v.we = 0; v.gu = 0; v.ipc = 0;
    v.rt = 0; v.rpc = 0; v.ev = 0; v.mc = 0; v.cc = 0; v.epc = 0;
    v.ep = 0; v.ef = 0; v.ec = 0;
    return v;
  endfunction

  function automatic vec_t v_inj(input bit [2:0] ty, input bit [1:0] ps, input bit we,
                                 input bit gu, input bit [31:0] pc, input bit [2:0] ec);
    vec_t v = v_idle();
    v.iv = 1; v.ty = ty; v.ps = ps; v.we = we; v.gu = gu; v.ipc = pc; v.ec = ec;
    return v;
  endfunction

  function automatic vec_t v_exc(input bit [5:0] mc, input bit [4:0] cc, input bit [31:0] pc,
                                 input bit ep, input bit ef, input bit [2:0] ec);
    vec_t v = v_idle();
    v.ev = 1; v.mc = mc; v.cc = cc; v.epc = pc; v.ep = ep; v.ef = ef; v.ec = ec;
    return v;
  endfunction

  function automatic vec_t v_ret(input bit [31:0] pc, input bit ef, input bit [2:0] ec);
    vec_t v = v_idle();
    v.rt = 1; v.rpc = pc; v.ef = ef; v.ec = ec;
    return v;
  endfunction

  task automatic apply(input vec_t v);
    inj_valid = v.iv; inj_type = v.ty; inj_perm_sel = v.ps; inj_we = v.we; inj_giveup = v.gu;
    inj_pc = v.ipc; instr_retire = v.rt; retire_pc = v.rpc; exc_valid = v.ev;
    exc_mcause = v.mc; exc_cheri_cause = v.cc; exc_pc = v.epc;
  endtask

  task automatic arm_align_store(input logic [31:0] pc);
    idle_inputs(); inj_valid = 1; inj_type = 3'd4; inj_we = 1; inj_pc = pc;
    drive_cycle();
    idle_inputs();
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    logic [31:0] pool [4];

    // Tag pass after three quiet cycles, perm mismatch, bound retire, idle retire/giveup.
    tbl.push_back(v_inj(3'd0, 2'd0, 0, 0, 32'h100, 3'd0));
    for (int i = 0; i < 3; i++) tbl.push_back(v_idle());
    tbl.push_back(v_exc(6'h1C, 5'h02, 32'h100, 1, 0, 3'd0));
    tbl.push_back(v_idle());
    tbl.push_back(v_inj(3'd2, 2'd1, 1, 0, 32'h180, 3'd0));
    tbl.push_back(v_exc(6'h1C, 5'h12, 32'h180, 0, 1, 3'd1));
    tbl.push_back(v_inj(3'd3, 2'd0, 0, 0, 32'h200, 3'd1));
    tbl.push_back(v_ret(32'h200, 1, 3'd2));
    tbl.push_back(v_ret(32'h204, 0, 3'd2));
    tbl.push_back(v_inj(3'd0, 2'd0, 0, 1, 32'h400, 3'd2));
    tbl.push_back(v_exc(6'h1C, 5'h02, 32'h400, 0, 0, 3'd2));
    // Seal held four cycles, then a new pc overruns and re-arms.
    for (int i = 0; i < 4; i++) tbl.push_back(v_inj(3'd1, 2'd0, 0, 0, 32'h300, 3'd2));
    v = v_inj(3'd1, 2'd0, 0, 0, 32'h304, 3'd4); v.ef = 1; tbl.push_back(v);
    tbl.push_back(v_exc(6'h1C, 5'h03, 32'h304, 1, 0, 3'd4));
    // Unrelated trap ignored; exception beats retire on the same pc.
    tbl.push_back(v_inj(3'd0, 2'd0, 0, 0, 32'h500, 3'd4));
    tbl.push_back(v_exc(6'h1C, 5'h02, 32'h504, 0, 0, 3'd4));
    v = v_exc(6'h1C, 5'h02, 32'h500, 1, 0, 3'd4); v.rt = 1; v.rpc = 32'h500; tbl.push_back(v);
    // Aligned load ignores cheri_cause; giveup while waiting is ignored.
    tbl.push_back(v_inj(3'd4, 2'd0, 0, 0, 32'h600, 3'd4));
    tbl.push_back(v_exc(6'd4, 5'h1F, 32'h600, 1, 0, 3'd4));
    tbl.push_back(v_inj(3'd2, 2'd2, 0, 0, 32'h700, 3'd4));
    tbl.push_back(v_inj(3'd0, 2'd0, 0, 1, 32'h708, 3'd4));
    tbl.push_back(v_exc(6'h1C, 5'h15, 32'h700, 1, 0, 3'd4));
    // Retire outranks overrun; the new injection in that cycle is dropped.
    tbl.push_back(v_inj(3'd3, 2'd0, 0, 0, 32'h800, 3'd4));
    v = v_inj(3'd3, 2'd0, 0, 0, 32'h804, 3'd2); v.rt = 1; v.rpc = 32'h800; v.ef = 1; tbl.push_back(v);
    tbl.push_back(v_exc(6'h1C, 5'h01, 32'h804, 0, 0, 3'd2));

    idle_inputs();
    rst_n = 0;
    drive_cycle();
    drive_cycle();
    check("reset_state", {chk_pass, chk_fail, fail_code, fail_sticky, pass_cnt, fail_cnt}, 38'd0);
    rst_n = 1;

    foreach (tbl[i]) begin
      apply(tbl[i]);
      drive_cycle();
      check($sformatf("vec%0d", i), {chk_pass, chk_fail, fail_code},
            {tbl[i].ep, tbl[i].ef, tbl[i].ec});
    end

    // Timeout fires on the 64th cycle after arming, not earlier.
    arm_align_store(32'h900);
    for (int k = 1; k <= TO; k++) begin
      drive_cycle();
      if (k == TO - 1) check("no_timeout_63", {chk_pass, chk_fail}, 2'b00);
      if (k == TO) check("timeout_64", {chk_fail, fail_code}, {1'b1, 3'd3});
    end
    // Matching store trap on cycle 63 still passes.
    arm_align_store(32'h940);
    for (int k = 1; k < TO - 1; k++) drive_cycle();
    exc_valid = 1; exc_mcause = 6'd6; exc_pc = 32'h940;
    drive_cycle();
    check("align_pass_63", {chk_pass, chk_fail}, 2'b10);
    idle_inputs();

    // Reset mid-wait discards the expectation with no pulse.
    idle_inputs(); inj_valid = 1; inj_pc = 32'hA00; drive_cycle();
    idle_inputs(); drive_cycle(); drive_cycle();
    rst_n = 0; exc_valid = 1; exc_mcause = 6'h1C; exc_cheri_cause = 5'h02; exc_pc = 32'hA00;
    drive_cycle();
    check("rst_mid_wait", {chk_pass, chk_fail, fail_code, fail_sticky, pass_cnt, fail_cnt}, 38'd0);
    rst_n = 1;
    drive_cycle();
    check("post_rst_discard", {chk_pass, chk_fail}, 2'b00);
    idle_inputs();

    // Five fails: narrow counter holds at 3.
    for (int n = 0; n < 5; n++) begin
      idle_inputs(); inj_valid = 1; inj_type = 3'd3; inj_pc = 32'hB00 + 32'(n * 4); drive_cycle();
      idle_inputs(); instr_retire = 1; retire_pc = 32'hB00 + 32'(n * 4); drive_cycle();
      if (n == 2) check("sat_reach3", fail_cnt2, 2'd3);
    end
    check("sat_hold3", {fail_cnt2, fail_cnt}, {2'd3, 16'd5});
    idle_inputs();

    pool = '{32'h10, 32'h14, 32'h18, 32'h1C};
    for (int c = 0; c < 3000; c++) begin
      rst_n        = ($urandom_range(0, 499) != 0);
      inj_valid    = ($urandom_range(0, 99) < 12);
      inj_giveup   = ($urandom_range(0, 9) == 0);
      inj_type     = 3'($urandom_range(0, 4));
      inj_perm_sel = 2'($urandom_range(0, 2));
      inj_we       = 1'($urandom_range(0, 1));
      inj_pc       = pool[$urandom_range(0, 3)];
      instr_retire = ($urandom_range(0, 99) < 5);
      retire_pc    = pool[$urandom_range(0, 3)];
      exc_valid    = ($urandom_range(0, 99) < 6);
      exc_pc       = pool[$urandom_range(0, 3)];
      case ($urandom_range(0, 3))
        0, 1:    exc_mcause = 6'h1C;
        2:       exc_mcause = ($urandom_range(0, 1) != 0) ? 6'd6 : 6'd4;
        default: exc_mcause = 6'($urandom_range(0, 63));
      endcase
      case ($urandom_range(0, 6))
        0:       exc_cheri_cause = 5'h01;
        1:       exc_cheri_cause = 5'h02;
        2:       exc_cheri_cause = 5'h03;
        3:       exc_cheri_cause = 5'h12;
        4:       exc_cheri_cause = 5'h13;
        5:       exc_cheri_cause = 5'h15;
        default: exc_cheri_cause = 5'($urandom_range(0, 31));
      endcase
      drive_cycle();
    end

    $display("%0d/%0d checks passed", n_pass, n_pass + n_fail);
    $finish;
  end
endmodule
